// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 style TAP state machine with registered decode outputs
// Outputs are flops loaded from a decode of next_state, so they always match State.
module tap_controller (
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  output logic [3:0] State,
  output logic       Test_Reset,
  output logic       Run_Idle,
  output logic       Capture_DR,
  output logic       Shift_DR,
  output logic       Update_DR,
  output logic       Capture_IR,
  output logic       Shift_IR,
  output logic       Update_IR,
  output logic       Select_IR,
  output logic       TDO_En
);

  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  logic [3:0] next_state;
  logic       test_reset_d, run_idle_d, capture_dr_d, shift_dr_d, update_dr_d;
  logic       capture_ir_d, shift_ir_d, update_ir_d, select_ir_d, tdo_en_d;

  always_ff @(posedge TCK) begin
    if (!TRST_n) begin
      State      <= TLR;
      Test_Reset <= 1'b1;
      Run_Idle   <= 1'b0;
      Capture_DR <= 1'b0;
      Shift_DR   <= 1'b0;
      Update_DR  <= 1'b0;
      Capture_IR <= 1'b0;
      Shift_IR   <= 1'b0;
      Update_IR  <= 1'b0;
      Select_IR  <= 1'b0;
      TDO_En     <= 1'b0;
    end else begin
      State      <= next_state;
      Test_Reset <= test_reset_d;
      Run_Idle   <= run_idle_d;
      Capture_DR <= capture_dr_d;
      Shift_DR   <= shift_dr_d;
      Update_DR  <= update_dr_d;
      Capture_IR <= capture_ir_d;
      Shift_IR   <= shift_ir_d;
      Update_IR  <= update_ir_d;
      Select_IR  <= select_ir_d;
      TDO_En     <= tdo_en_d;
    end
  end

  always_comb begin
    next_state = State;
    case (State)
      TLR:    next_state = TMS ? TLR    : RTI;
      RTI:    next_state = TMS ? SEL_DR : RTI;
      SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR: next_state = TMS ? UPD_DR : PAU_DR;
      PAU_DR: next_state = TMS ? EX2_DR : PAU_DR;
      EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR: next_state = TMS ? SEL_DR : RTI;
      SEL_IR: next_state = TMS ? TLR    : CAP_IR;
      CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR: next_state = TMS ? UPD_IR : PAU_IR;
      PAU_IR: next_state = TMS ? EX2_IR : PAU_IR;
      EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR: next_state = TMS ? SEL_DR : RTI;
    endcase
  end

  always_comb begin
    test_reset_d = (next_state == TLR);
    run_idle_d   = (next_state == RTI);
    capture_dr_d = (next_state == CAP_DR);
    shift_dr_d   = (next_state == SH_DR);
    update_dr_d  = (next_state == UPD_DR);
    capture_ir_d = (next_state == CAP_IR);
    shift_ir_d   = (next_state == SH_IR);
    update_ir_d  = (next_state == UPD_IR);
    tdo_en_d     = (next_state == SH_DR) || (next_state == SH_IR);
    // IR column: Select-IR-Scan through Update-IR
    select_ir_d  = (next_state == SEL_IR) || (next_state == CAP_IR) ||
                   (next_state == SH_IR)  || (next_state == EX1_IR) ||
                   (next_state == PAU_IR) || (next_state == EX2_IR) ||
                   (next_state == UPD_IR);
  end

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - self-checking bench for tap_controller against a transition-table model
module tb_tap_controller;

  logic       TCK = 1'b0;
  logic       TRST_n = 1'b0;
  logic       TMS = 1'b0;
  logic [3:0] State;
  logic       Test_Reset, Run_Idle, Capture_DR, Shift_DR, Update_DR;
  logic       Capture_IR, Shift_IR, Update_IR, Select_IR, TDO_En;

  int checks = 0;
  int errors = 0;

  logic [3:0] ms;
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];

  tap_controller dut (
    .TCK(TCK), .TRST_n(TRST_n), .TMS(TMS), .State(State),
    .Test_Reset(Test_Reset), .Run_Idle(Run_Idle),
    .Capture_DR(Capture_DR), .Shift_DR(Shift_DR), .Update_DR(Update_DR),
    .Capture_IR(Capture_IR), .Shift_IR(Shift_IR), .Update_IR(Update_IR),
    .Select_IR(Select_IR), .TDO_En(TDO_En)
  );

  always #5 TCK = ~TCK;

  function automatic logic [9:0] exp_flags(input logic [3:0] s);
    logic sel;
    sel = (s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD});
    return {s == 4'hF, s == 4'hC, s == 4'h6, s == 4'h2, s == 4'h5,
            s == 4'hE, s == 4'hA, s == 4'hD, sel, (s == 4'h2) || (s == 4'hA)};
  endfunction

  function automatic logic [9:0] dut_flags();
    return {Test_Reset, Run_Idle, Capture_DR, Shift_DR, Update_DR,
            Capture_IR, Shift_IR, Update_IR, Select_IR, TDO_En};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, " state"}, {28'd0, State}, {28'd0, ms});
    check_val({tag, " flags"}, {22'd0, dut_flags()}, {22'd0, exp_flags(ms)});
    check_val({tag, " onehot"}, {31'd0, $countones(dut_flags() & 10'b1111_1111_00) <= 1}, 32'd1);
  endtask

  task automatic step(input logic tms, input logic rst_n);
    TMS = tms;
    TRST_n = rst_n;
    @(posedge TCK);
    #1;
    if (!rst_n) ms = 4'hF;
    else ms = tms ? nx1[ms] : nx0[ms];
  endtask

  initial begin
    logic [3:0] seq_dr [9];
    logic [3:0] seq_ir [9];
    logic [8:0] tms_dr;
    logic [8:0] tms_ir;
    int cnt_cap, cnt_sh, cnt_upd, cnt_tdo, cnt_sel, cnt_shir;
    int walk;

    // Transition table: nx0 for TMS=0, nx1 for TMS=1, indexed by state code
    nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
    nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
    nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
    nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
    nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
    nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
    nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
    nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
    nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
    nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
    nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
    nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
    nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
    nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
    nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
    nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;

    ms = 4'hF;
    step(1'($urandom), 1'b0);
    check_all("reset");

    // DR scan: TMS applied left to right (MSB first)
    tms_dr = 9'b010000110;
    seq_dr = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h1, 4'h5, 4'hC};
    cnt_cap = 0; cnt_sh = 0; cnt_upd = 0; cnt_tdo = 0;
    for (int i = 0; i < 9; i++) begin
      step(tms_dr[8 - i], 1'b1);
      check_val("dr_seq", {28'd0, State}, {28'd0, seq_dr[i]});
      check_all("dr_scan");
      cnt_cap += int'(Capture_DR);
      cnt_sh  += int'(Shift_DR);
      cnt_upd += int'(Update_DR);
      cnt_tdo += int'(TDO_En && Shift_DR);
    end
    check_val("dr_capture_cycles", cnt_cap, 1);
    check_val("dr_shift_cycles", cnt_sh, 3);
    check_val("dr_update_cycles", cnt_upd, 1);
    check_val("dr_tdo_en_cycles", cnt_tdo, 3);

    tms_ir = 9'b110010110;
    seq_ir = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD, 4'hC};
    cnt_sel = 0; cnt_shir = 0; cnt_tdo = 0;
    for (int i = 0; i < 9; i++) begin
      step(tms_ir[8 - i], 1'b1);
      check_val("ir_seq", {28'd0, State}, {28'd0, seq_ir[i]});
      check_all("ir_scan");
      cnt_sel  += int'(Select_IR);
      cnt_shir += int'(Shift_IR);
      cnt_tdo  += int'(TDO_En);
    end
    check_val("ir_select_cycles", cnt_sel, 7);
    check_val("ir_shift_cycles", cnt_shir, 1);
    check_val("ir_tdo_en_cycles", cnt_tdo, 1);

    // Five TMS=1 reach TLR from every state; random walk finds each start state
    for (int t = 0; t < 16; t++) begin
      walk = 0;
      while (ms != 4'(t) && walk < 2000) begin
        step(1'($urandom), 1'b1);
        check_all("walk");
        walk++;
      end
      check_val("walk_reached", {28'd0, ms}, t);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
      check_val("five_ones_state", {28'd0, State}, 32'hF);
      check_val("five_ones_test_reset", {31'd0, Test_Reset}, 32'd1);
      check_all("five_ones");
    end

    // Reset mid-scan in Shift-DR
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_val("in_shdr", {28'd0, State}, 32'h2);
    step(1'b0, 1'b0);
    check_val("trst_state", {28'd0, State}, 32'hF);
    check_val("trst_shift_dr", {31'd0, Shift_DR}, 32'd0);
    check_val("trst_tdo_en", {31'd0, TDO_En}, 32'd0);
    check_all("trst_midscan");
    step(1'b0, 1'b1);
    check_val("post_reset_first", {28'd0, State}, 32'hC);
    step(1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      check_val("tlr_hold_state", {28'd0, State}, 32'hF);
      check_val("tlr_hold_flags", {22'd0, dut_flags()}, {22'd0, 10'b1000000000});
    end

    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom), ($urandom_range(0, 255) != 0));
      check_all("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 TCK  input  1  test clock; all state and output flops update on the rising edge.
REQ-003 TRST_n  input  1  reset, synchronous to TCK, active-low.
REQ-004 TMS  input  1  test mode select, sampled on rising TCK.
REQ-005 State  output  4  current TAP state code, per REQ-016.
REQ-006 Test_Reset  output  1  high while in Test-Logic-Reset.
REQ-007 Run_Idle  output  1  high while in Run-Test/Idle; starts BIST.
REQ-008 Capture_DR  output  1  high while in Capture-DR.
REQ-009 Shift_DR  output  1  high while in Shift-DR.
REQ-010 Update_DR  output  1  high while in Update-DR.
REQ-011 Capture_IR  output  1  high while in Capture-IR.
REQ-012 Shift_IR  output  1  high while in Shift-IR.
REQ-013 Update_IR  output  1  high while in Update-IR.
REQ-014 Select_IR  output  1  high in the IR column: Select-IR-Scan through Update-IR; drives the TDO mux.
REQ-015 TDO_En  output  1  high while in Shift-DR or Shift-IR.

Function
REQ-016 The FSM SHALL use these 4-bit state codes:
- TLR=F, RTI=C
- SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
REQ-017 Next state for TMS=0 / TMS=1:
- TLR: RTI / TLR
- RTI: RTI / SelDR
- SelDR: CapDR / SelIR
- SelIR: CapIR / TLR
REQ-018 Next state in the DR column, TMS=0 / TMS=1:
- Cap: Sh / Ex1
- Sh: Sh / Ex1
- Ex1: Pau / Upd
- Pau: Pau / Ex2
- Ex2: Sh / Upd
- Upd: RTI / SelDR
REQ-019 The IR column SHALL follow the same transitions as REQ-018, with UpdIR going to RTI / SelDR.
REQ-020 All 16 codes are legal. No unreachable or illegal state SHALL exist.
REQ-021 All outputs in REQ-006..REQ-015 SHALL be flops loaded from a decode of the next state, so each output equals a decode of State in every cycle.
REQ-022 No combinational path SHALL exist from TMS to any output.
REQ-023 Latency: TMS sampled at rising edge n SHALL be reflected in State and all outputs immediately after edge n, for the whole TCK period up to edge n+1. This lets the downstream gating (flag AND enable AND TCK) pulse during the high phase of that period.
REQ-024 Among Test_Reset, Run_Idle, Capture_DR/IR, Shift_DR/IR and Update_DR/IR, at most one SHALL be high in any cycle.
REQ-025 Five consecutive TMS=1 samples SHALL reach TLR from any state, without TRST_n.
REQ-026 TMS held at 1 while in TLR SHALL keep the FSM in TLR with outputs stable.

Reset
REQ-027 TRST_n=0 at a rising TCK SHALL force State=F, Test_Reset=1 and all other outputs=0, regardless of TMS.
REQ-028 Reset SHALL take priority over any transition, including mid-scan in ShDR or ShIR. There SHALL be no partial-state residue after reset.
REQ-029 After TRST_n returns high, the first transition SHALL use TMS sampled at the next rising TCK.

Verification
REQ-030 Reset, then TMS=0,1,0,0,0,0,1,1,0:
- State=C,7,6,2,2,2,1,5,C
- Capture_DR for one cycle, Shift_DR for 3, Update_DR for 1
- TDO_En high for exactly those 3 Shift_DR cycles.
REQ-031 From RTI, TMS=1,1,0,0,1,0,1,1,0:
- State=7,4,E,A,9,B,8,D,C
- Select_IR high from state 4 through D
- Shift_IR and TDO_En high for one cycle.
REQ-032 From each of the 16 states, apply TMS=1 for five cycles: State=F and Test_Reset=1 after the fifth edge.
REQ-033 In ShDR with TMS=0, assert TRST_n=0 for one edge: the next State=F, Shift_DR=0 and TDO_En=0 on that edge.
REQ-034 Run random TMS for 10k cycles against a reference transition table: State matches every cycle, and the REQ-024 exclusivity holds every cycle.
REQ-035 Hold TMS=1 in TLR for 20 cycles: State stays F, Test_Reset=1, and no other output toggles.
